// File: rtl/mdu_issue.sv
// Queues mul/div requests from execute and launches them one at a time into the mul/div unit.
// Latency: a request pushed on edge E reaches the unit as a one-cycle md_start in the cycle after E+1.
// Backpressure: req_ready drops when DEPTH entries are queued; MFHI/MFLO reads stall until all work drains.
module mdu_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        rd_req,
  output logic        stall,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_srcA,
  output logic [31:0] md_srcB,
  input  logic        md_busy,
  output logic [2:0]  pending_cnt
);

  localparam int              PW      = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]      DEPTH_C = 3'(DEPTH);
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          md_start_q, md_start_d;
  logic [2:0]    md_op_q, md_op_d;
  logic [31:0]   srca_q, srca_d;
  logic [31:0]   srcb_q, srcb_d;

  logic [2:0]    fifo_op [DEPTH];
  logic [31:0]   fifo_a  [DEPTH];
  logic [31:0]   fifo_b  [DEPTH];

  logic          push_en;
  logic          pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Illegal opcodes are dropped silently; a flush discards the incoming request too.
  assign req_ready = (count_q < DEPTH_C);
  assign push_en   = req_valid && req_ready && (req_op < 3'd6) && !flush;
  assign pop_en    = (state_q == IDLE) && (count_q != 3'd0) && !md_busy;

  assign stall       = rd_req && ((count_q != 3'd0) || (state_q != IDLE) || md_busy);
  assign pending_cnt = count_q + {2'b00, (state_q != IDLE)};

  assign md_start = md_start_q;
  assign md_op    = md_op_q;
  assign md_srcA  = srca_q;
  assign md_srcB  = srcb_q;

  // Request storage; entries carry no reset since only written slots are ever read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_op[wptr_q] <= req_op;
      fifo_a[wptr_q]  <= req_a;
      fifo_b[wptr_q]  <= req_b;
    end
  end

  // FIFO pointer/count next state; flush wins over push but leaves an in-progress pop's launch intact.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = 3'd0;
    end else begin
      if (push_en) wptr_d = ptr_inc(wptr_q);
      if (pop_en)  rptr_d = ptr_inc(rptr_q);
      count_d = count_q + {2'b00, push_en} - {2'b00, pop_en};
    end
  end

  // Issue FSM: pop head in IDLE, pulse md_start in LAUNCH, wait for the unit to go idle.
  always_comb begin
    state_d    = state_q;
    md_start_d = 1'b0;
    md_op_d    = md_op_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    case (state_q)
      IDLE: begin
        if (pop_en) begin
          state_d    = LAUNCH;
          md_start_d = 1'b1;
          md_op_d    = fifo_op[rptr_q];
          srca_d     = fifo_a[rptr_q];
          srcb_d     = fifo_b[rptr_q];
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (!md_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and launch registers; reset abandons any in-flight operation immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= 3'd0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      md_start_q <= 1'b0;
      md_op_q    <= 3'd0;
      srca_q     <= 32'd0;
      srcb_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      md_start_q <= md_start_d;
      md_op_q    <= md_op_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
    end
  end

endmodule

// File: tb/tb_mdu_issue.sv
// Bench for mdu_issue: DEPTH=2 and DEPTH=4 instances share stimulus, each with its own unit and reference model.
// Latency: reference model predicts every output each cycle; directed sequences check end-to-end timing.
// Backpressure: the bench holds req_valid until the reference model says the request is taken.
module tb_mdu_issue;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic        rv;
  logic [2:0]  rop;
  logic [31:0] ra, rb;
  logic        fl, rd;
  logic        busy2, busy4;

  logic        rdy2, rdy4, stl2, stl4, st2, st4;
  logic [2:0]  mop2, mop4, pc2, pc4;
  logic [31:0] msa2, msa4, msb2, msb4;

  int nchk  = 0;
  int npass = 0;

  // reference model: pending requests, operation in flight, and a phase of the issue slot
  req_t q2[$], q4[$];
  req_t cur[2];
  int   phase[2];     // 0: slot free, 1: launching this cycle, 2: waiting for the unit
  int   bcnt[2];
  bit   sseen[2];
  logic [2:0] opseen[2];
  logic [2:0]  logop2[$];
  logic [31:0] loga4[$];
  int   maxp4;

  mdu_issue #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(rst_n), .req_valid(rv), .req_ready(rdy2), .req_op(rop),
    .req_a(ra), .req_b(rb), .flush(fl), .rd_req(rd), .stall(stl2),
    .md_start(st2), .md_op(mop2), .md_srcA(msa2), .md_srcB(msb2),
    .md_busy(busy2), .pending_cnt(pc2)
  );

  mdu_issue #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(rst_n), .req_valid(rv), .req_ready(rdy4), .req_op(rop),
    .req_a(ra), .req_b(rb), .flush(fl), .rd_req(rd), .stall(stl4),
    .md_start(st4), .md_op(mop4), .md_srcA(msa4), .md_srcB(msb4),
    .md_busy(busy4), .pending_cnt(pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q2.size() : q4.size();
  endfunction

  function automatic int unit_latency(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  task automatic model_reset(input int k);
    if (k == 0) q2.delete(); else q4.delete();
    cur[k]   = '0;
    phase[k] = 0;
  endtask

  task automatic model_step(input int k);
    int   n;
    bit   push, pop, bz;
    req_t e;
    n    = qsize(k);
    bz   = (k == 0) ? busy2 : busy4;
    push = rv && (n < depth_of(k)) && (rop < 3'd6);
    pop  = (phase[k] == 0) && (n > 0) && !bz;
    if (pop) begin
      if (k == 0) e = q2.pop_front(); else e = q4.pop_front();
      cur[k]   = e;
      phase[k] = 1;
    end else if (phase[k] == 1) begin
      phase[k] = 2;
    end else if (phase[k] == 2 && !bz) begin
      phase[k] = 0;
    end
    if (fl) begin
      if (k == 0) q2.delete(); else q4.delete();
    end else if (push) begin
      e = {rop, ra, rb};
      if (k == 0) q2.push_back(e); else q4.push_back(e);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int n;
      logic g_rdy, g_stl, g_st, bz;
      logic [2:0] g_op, g_pc;
      logic [31:0] g_a, g_b;
      string s;
      n     = qsize(k);
      s     = (k == 0) ? "2" : "4";
      g_rdy = (k == 0) ? rdy2 : rdy4;
      g_stl = (k == 0) ? stl2 : stl4;
      g_st  = (k == 0) ? st2  : st4;
      g_op  = (k == 0) ? mop2 : mop4;
      g_pc  = (k == 0) ? pc2  : pc4;
      g_a   = (k == 0) ? msa2 : msa4;
      g_b   = (k == 0) ? msb2 : msb4;
      bz    = (k == 0) ? busy2 : busy4;
      chk({"ready", s}, {31'd0, g_rdy}, {31'd0, (n < depth_of(k))});
      chk({"pending", s}, {29'd0, g_pc}, n + ((phase[k] != 0) ? 1 : 0));
      chk({"stall", s}, {31'd0, g_stl}, {31'd0, rd && (n > 0 || phase[k] != 0 || bz)});
      chk({"start", s}, {31'd0, g_st}, {31'd0, (phase[k] == 1)});
      chk({"op", s}, {29'd0, g_op}, {29'd0, cur[k].op});
      chk({"srcA", s}, g_a, cur[k].a);
      chk({"srcB", s}, g_b, cur[k].b);
      sseen[k]  = g_st;
      opseen[k] = g_op;
    end
    if (st2) logop2.push_back(mop2);
    if (st4) loga4.push_back(msa4);
    if (int'(pc4) > maxp4) maxp4 = int'(pc4);
  endtask

  // one clock: check outputs mid-cycle, then advance the model and the mul/div unit stand-in
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k);
      if (!rst_n) bcnt[k] = 0;
      else if (sseen[k]) bcnt[k] = unit_latency(opseen[k]);
      else if (bcnt[k] > 0) bcnt[k]--;
    end
    busy2 = (bcnt[0] > 0);
    busy4 = (bcnt[1] > 0);
  endtask

  task automatic wait_idle(input int k);
    int c;
    c = 0;
    while ((qsize(k) > 0 || phase[k] != 0) && c < 200) begin
      tick();
      c++;
    end
    chk("idle_wait", {31'd0, (c < 200)}, 32'd1);
  endtask

  task automatic push_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rv = 1'b1; rop = op; ra = a; rb = b;
    tick();
    rv = 1'b0;
  endtask

  task automatic wait_start2();
    int c;
    c = 0;
    while (!st2 && c < 30) begin
      tick();
      c++;
    end
    chk("start_wait", {31'd0, st2}, 32'd1);
  endtask

  initial begin
    int n;
    bit acc;
    logic [31:0] expa[$];
    rst_n = 1'b0; rv = 1'b0; rop = 3'd0; ra = '0; rb = '0; fl = 1'b0; rd = 1'b1;
    busy2 = 1'b0; busy4 = 1'b0;
    bcnt[0] = 0; bcnt[1] = 0; maxp4 = 0;
    model_reset(0); model_reset(1);
    #2;
    chk("rst_ready", {31'd0, rdy2}, 32'd1);
    chk("rst_stall", {31'd0, stl2}, 32'd0);
    chk("rst_pending", {29'd0, pc2}, 32'd0);
    chk("rst_start", {31'd0, st2}, 32'd0);
    chk("rst_srcA", msa4, 32'd0);
    rd = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single MULT: launch two cycles after the push cycle, idle seven cycles after the pulse
    push_one(3'd0, 32'hFFFF_FFFE, 32'd3);
    n = 1;
    while (!st2 && n < 20) begin tick(); n++; end
    chk("mult_launch_delay", n, 32'd2);
    chk("mult_op", {29'd0, mop2}, 32'd0);
    chk("mult_srcA", msa2, 32'hFFFF_FFFE);
    chk("mult_srcB", msb2, 32'd3);
    n = 0;
    while (pc2 != 3'd0 && n < 20) begin tick(); n++; end
    chk("mult_idle_delay", n, 32'd7);

    // back-to-back DIV, MTLO, MULTU behind a MULT in flight
    wait_idle(0);
    logop2.delete();
    push_one(3'd0, 32'd7, 32'd8);
    wait_start2();
    push_one(3'd2, 32'd100, 32'd0);
    push_one(3'd5, 32'd200, 32'd0);
    chk("full_ready", {31'd0, rdy2}, 32'd0);
    acc = 1'b0; n = 0;
    while (!acc && n < 40) begin
      rv = 1'b1; rop = 3'd1; ra = 32'd300; rb = 32'd4;
      acc = (qsize(0) < 2);
      tick();
      n++;
    end
    rv = 1'b0;
    chk("multu_accepted", {31'd0, acc}, 32'd1);
    wait_idle(0);
    chk("order_len", logop2.size(), 32'd4);
    if (logop2.size() == 4) begin
      chk("order0", {29'd0, logop2[0]}, 32'd0);
      chk("order1", {29'd0, logop2[1]}, 32'd2);
      chk("order2", {29'd0, logop2[2]}, 32'd5);
      chk("order3", {29'd0, logop2[3]}, 32'd1);
    end

    // MFHI/MFLO stall across a 10-cycle DIVU
    wait_idle(0);
    rd = 1'b1;
    push_one(3'd3, 32'd9, 32'd0);
    n = 0;
    while (stl2 && n < 40) begin n++; tick(); end
    chk("divu_stall_cycles", n, 32'd13);
    chk("divu_stall_release_pc", {29'd0, pc2}, 32'd0);
    rd = 1'b0;

    // flush with a concurrent push while a MULT waits
    wait_idle(0);
    push_one(3'd0, 32'd11, 32'd12);
    wait_start2();
    tick();
    push_one(3'd2, 32'd13, 32'd1);
    push_one(3'd3, 32'd14, 32'd1);
    logop2.delete();
    fl = 1'b1;
    push_one(3'd4, 32'd15, 32'd0);
    fl = 1'b0;
    chk("flush_pending", {29'd0, pc2}, 32'd1);
    for (int i = 0; i < 30; i++) tick();
    chk("flush_no_launch", logop2.size(), 32'd0);
    chk("flush_mult_done", {29'd0, pc2}, 32'd0);

    // reset in the middle of LAUNCH
    wait_idle(0);
    push_one(3'd0, 32'd21, 32'd22);
    n = 0;
    while (phase[0] != 1 && n < 20) begin tick(); n++; end
    chk("pre_reset_start", {31'd0, st2}, 32'd1);
    rd = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start", {31'd0, st2}, 32'd0);
    chk("arst_pending", {29'd0, pc2}, 32'd0);
    chk("arst_ready", {31'd0, rdy2}, 32'd1);
    chk("arst_stall", {31'd0, stl2}, 32'd0);
    model_reset(0); model_reset(1);
    bcnt[0] = 0; bcnt[1] = 0; busy2 = 1'b0; busy4 = 1'b0;
    rd = 1'b0;
    tick();
    rst_n = 1'b1;
    push_one(3'd4, 32'h55, 32'h66);
    wait_start2();
    chk("post_reset_op", {29'd0, mop2}, 32'd4);
    chk("post_reset_srcA", msa2, 32'h55);

    // DEPTH=4: six queued MULT/MULTU across pointer wrap
    wait_idle(0);
    wait_idle(1);
    loga4.delete();
    maxp4 = 0;
    for (int i = 0; i < 6; i++) begin
      acc = 1'b0; n = 0;
      while (!acc && n < 50) begin
        rv = 1'b1; rop = (i % 2 == 1) ? 3'd1 : 3'd0; ra = 32'd100 + 32'(i); rb = 32'(i);
        acc = (qsize(1) < 4);
        tick();
        n++;
      end
      if (acc) expa.push_back(32'd100 + 32'(i));
    end
    rv = 1'b0;
    wait_idle(1);
    chk("wrap_len", loga4.size(), 32'd6);
    for (int i = 0; i < 6 && i < loga4.size() && i < expa.size(); i++)
      chk("wrap_order", loga4[i], expa[i]);
    chk("wrap_maxpend", maxp4, 32'd5);

    // randomized traffic, every cycle compared against the model
    for (int i = 0; i < 1500; i++) begin
      rv  = 1'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      fl  = ($urandom_range(0, 39) == 0);
      rd  = 1'($urandom_range(0, 1));
      tick();
    end
    rv = 1'b0; fl = 1'b0; rd = 1'b0;
    wait_idle(0);
    wait_idle(1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mdu_issue.md
MDU_ISSUE -- requirements
Module: mdu_issue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 2, holding the request FIFO depth; the legal values are 2 and 4.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have the port reset, input, 1 bit, an asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the port req_valid, input, 1 bit, the execute-stage muldiv request strobe.
REQ-005 The block SHALL have the port req_ready, output, 1 bit, meaning the FIFO can accept a request.
REQ-006 The block SHALL have the port req_op, input, 3 bits, the opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; values 6 and 7 are illegal.
REQ-007 The block SHALL have the ports req_a and req_b, input, 32 bits each, the rs and rt operand values.
REQ-008 The block SHALL have the port flush, input, 1 bit, which discards requests that are queued and not yet issued.
REQ-009 The block SHALL have the port rd_req, input, 1 bit, meaning an MFHI or MFLO is present in execute.
REQ-010 The block SHALL have the port stall, output, 1 bit, the pipeline hold request for that read.
REQ-011 The block SHALL have the ports md_start, output, 1 bit; md_op, output, 3 bits; md_srcA, output, 32 bits; and md_srcB, output, 32 bits; these are the registered launch signals to the mul/div unit.
REQ-012 The block SHALL have the port md_busy, input, 1 bit, the busy flag from the mul/div unit, which rises the cycle after the start edge.
REQ-013 The block SHALL have the port pending_cnt, output, 3 bits, equal to the FIFO count plus 1 when the FSM is not in IDLE.

Function
REQ-014 The FIFO SHALL accept a push on a rising edge when req_valid and req_ready are both 1; req_ready SHALL be 1 exactly when count < DEPTH.
REQ-015 A push and a pop in the same cycle SHALL leave count unchanged; there SHALL be no bypass, so a pushed entry is poppable at the earliest on the next cycle.
REQ-016 The read and write pointers SHALL wrap modulo DEPTH; a push with req_op 6 or 7 SHALL be dropped and SHALL NOT change count.
REQ-017 The FSM SHALL have exactly three states: IDLE, LAUNCH and WAIT.
REQ-018 In IDLE, when count > 0 and md_busy = 0, the block SHALL pop the head entry, register its op, a and b into md_op, md_srcA and md_srcB, and move to LAUNCH; otherwise it SHALL remain in IDLE.
REQ-019 In LAUNCH, md_start SHALL be 1 for exactly one cycle and md_op, md_srcA and md_srcB SHALL be stable; the next state SHALL be WAIT unconditionally.
REQ-020 In WAIT, the FSM SHALL move to IDLE on a cycle where md_busy = 0 and SHALL remain in WAIT otherwise.
REQ-021 Because MTHI and MTLO leave md_busy low, an MTHI or MTLO SHALL spend exactly 1 cycle in WAIT.
REQ-022 md_start SHALL be 0 in every state other than LAUNCH; md_srcA, md_srcB and md_op SHALL hold their last value outside LAUNCH.
REQ-023 stall SHALL be combinational and equal to rd_req AND (count > 0 OR state != IDLE OR md_busy).
REQ-024 Operands SHALL be passed through unmodified; a zero divisor or an overflow SHALL NOT be detected or altered.
REQ-025 When flush is 1, the block SHALL set count and both pointers to 0 on the next edge, and flush SHALL take priority over a simultaneous push.
REQ-026 flush SHALL NOT affect LAUNCH or WAIT: an operation already issued SHALL complete.
REQ-027 For a MULT popped in cycle N: LAUNCH SHALL occur in N+1, md_busy SHALL be high in N+2..N+6, WAIT SHALL span N+2..N+7, and IDLE SHALL be reached in N+8.
REQ-028 The earliest next pop after that MULT SHALL be in N+8.

Reset
REQ-029 When reset = 0, the block SHALL immediately set: state IDLE, count 0, pointers 0, md_start 0, md_op 0, md_srcA 0, md_srcB 0.
REQ-030 During reset, the outputs SHALL be req_ready 1, stall 0 and pending_cnt 0.
REQ-031 Reset asserted in LAUNCH SHALL drop md_start within the same cycle.
REQ-032 Reset SHALL abandon any in-flight operation without any further launch.
REQ-033 The block SHALL leave reset on the first rising edge after reset returns to 1.

Verification
REQ-034 The bench SHALL check: push MULT a=0xFFFFFFFE, b=3 into an empty FIFO -> md_start pulses 2 cycles after the push edge with md_srcA=0xFFFFFFFE, md_srcB=3, md_op=0, and IDLE is reached 7 cycles after the pulse.
REQ-035 The bench SHALL check: push DIV, MTLO and MULTU back-to-back with DEPTH=2 -> req_ready is 0 after the second push, the third push is accepted once DIV pops, and launch order is DIV, MTLO, MULTU.
REQ-036 The bench SHALL check: rd_req=1 held while DIVU is in WAIT with md_busy high for 10 cycles -> stall is 1 throughout and falls to 0 only on the first IDLE cycle with count 0.
REQ-037 The bench SHALL check: flush together with req_valid while 2 entries are queued and MULT is in WAIT -> count=0 next cycle, MULT still completes, and no further md_start occurs.
REQ-038 The bench SHALL check: reset asserted mid-LAUNCH -> md_start=0 in the same cycle, pending_cnt=0, and a push after release launches normally.
REQ-039 The bench SHALL check: with DEPTH=4, perform 6 push/pop cycles crossing pointer wrap -> launch order matches push order and pending_cnt never exceeds 5.
